// File: rtl/hazard_fault_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fault_ctrl
//   Hazard and fault controller for the 5-stage RV32 pipeline.
//   - Operand forwarding selects for the two ALU sources in Execute.
//   - Load-use stall sequencer that inserts LOAD_LAT bubbles.
//   - Branch/jump flush of the Decode and Execute registers.
//   - Optional non-forwarding mode (FWD_EN=0) where RAW hazards are stalled.
//   - Saturating counter of corrected (single-bit) ECC errors.
//   - HALT state on any fatal fault (double-bit ECC or ALU BIST fault).
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   rs1_d, rs2_d              source registers of the instruction in Decode
//   rs1_e, rs2_e              source registers of the instruction in Execute
//   rd_e, rd_m, rd_w          destination registers in Execute/Memory/Writeback
//   regwrite_e/m/w            destination write enables
//   resultsrc_e               instruction in Execute is a load
//   pcsrc_e                   taken branch/jump resolved in Execute
//   s_err_imem, s_err_dmem    corrected ECC error flags
//   d_err_imem, d_err_dmem    uncorrectable ECC error flags
//   hw_fault_in               ALU BIST fault flag
//   forward_ae, forward_be    00 register file, 01 ResultW, 10 ALU_ResultM
//   stall_f, stall_d          hold PC / IF-ID register
//   flush_d, flush_e          bubble IF-ID / ID-EX register
//   halt                      pipeline frozen on fatal fault
//   fault_code                {hw_fault, d_err_dmem, d_err_imem} at HALT entry
//   ce_count                  saturating corrected-error count
// -----------------------------------------------------------------------------
module hazard_fault_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  regwrite_e,
    input  logic                  regwrite_m,
    input  logic                  regwrite_w,
    input  logic                  resultsrc_e,
    input  logic                  pcsrc_e,
    input  logic                  s_err_imem,
    input  logic                  s_err_dmem,
    input  logic                  d_err_imem,
    input  logic                  d_err_dmem,
    input  logic                  hw_fault_in,
    output logic [1:0]            forward_ae,
    output logic [1:0]            forward_be,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  halt,
    output logic [2:0]            fault_code,
    output logic [CNT_W-1:0]      ce_count
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, HALT} state_t;

    state_t     state, state_nx;
    logic [2:0] lat_cnt, lat_cnt_nx;

    // A destination matches a source only when it is written and is not x0.
    function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rd,
                                     input logic                  we,
                                     input logic [REG_ADDR_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    logic [1:0] fwd_a, fwd_b;
    logic       load_use, raw_nf, fatal;

    always_comb begin
        fwd_a = 2'b00;
        if (reg_hit(rd_m, regwrite_m, rs1_e))      fwd_a = 2'b10;
        else if (reg_hit(rd_w, regwrite_w, rs1_e)) fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (reg_hit(rd_m, regwrite_m, rs2_e))      fwd_b = 2'b10;
        else if (reg_hit(rd_w, regwrite_w, rs2_e)) fwd_b = 2'b01;
    end

    assign forward_ae = (FWD_EN != 0) ? fwd_a : 2'b00;
    assign forward_be = (FWD_EN != 0) ? fwd_b : 2'b00;

    assign load_use = resultsrc_e &&
                      (reg_hit(rd_e, regwrite_e, rs1_d) || reg_hit(rd_e, regwrite_e, rs2_d));

    // Without forwarding, any in-flight producer in E or M blocks Decode.
    // Writeback is covered by the write-first register file.
    assign raw_nf = (FWD_EN == 0) &&
                    (reg_hit(rd_e, regwrite_e, rs1_d) || reg_hit(rd_e, regwrite_e, rs2_d) ||
                     reg_hit(rd_m, regwrite_m, rs1_d) || reg_hit(rd_m, regwrite_m, rs2_d));

    assign fatal = d_err_imem | d_err_dmem | hw_fault_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= RUN;
            lat_cnt <= '0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        halt       = 1'b0;
        case (state)
            RUN: begin
                if (fatal) begin
                    state_nx = HALT;
                end else if (pcsrc_e) begin
                    // Branch wins: the load-use consumer is being flushed anyway.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nx   = LOAD_STALL;
                        lat_cnt_nx = 3'(LOAD_LAT - 1);
                    end
                end else if (raw_nf) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            LOAD_STALL: begin
                if (fatal) begin
                    state_nx = HALT;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    if (lat_cnt <= 3'd1) state_nx = RUN;
                    else                 lat_cnt_nx = lat_cnt - 3'd1;
                end
            end
            HALT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                halt    = 1'b1;
            end
            default: state_nx = RUN;
        endcase
    end

    // Fault cause is captured on the edge that enters HALT and held there.
    always_ff @(posedge clk) begin
        if (!rst)
            fault_code <= 3'b000;
        else if (state != HALT && fatal)
            fault_code <= {hw_fault_in, d_err_dmem, d_err_imem};
    end

    // At most one increment per cycle, even when both memories report.
    always_ff @(posedge clk) begin
        if (!rst)
            ce_count <= '0;
        else if ((s_err_imem || s_err_dmem) && (ce_count != {CNT_W{1'b1}}))
            ce_count <= ce_count + 1'b1;
    end

endmodule
